// File: rtl/sdram_gated_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdram_gated_arb
// Description : Round-robin arbiter that lets NPORTS clock-enable-gated
//               clients share a single RAM request/accept/ack interface.
//               Each client request is captured on its port_ce_i strobe,
//               queued as pending, granted round-robin and completed on
//               ram_ack_i or on a per-transaction timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_ram           : single clock for the whole block
//   rst               : synchronous active-high reset
//   ram_wr_o          : RAM byte write strobes (DW/8 bits)
//   ram_rd_o          : RAM read request
//   ram_addr_o        : RAM address
//   ram_write_data_o  : RAM write data
//   ram_read_data_i   : RAM read data, valid with ram_ack_i
//   ram_accept_i      : RAM has taken the presented request
//   ram_ack_i         : RAM has completed the request
//   ram_error_i       : RAM error status, valid with ram_ack_i
//   port_ce_i         : per-port client-cycle strobe
//   port_wr_i         : per-port byte write strobes, port p at [p*SW +: SW]
//   port_rd_i         : per-port read request
//   port_addr_i       : per-port address, port p at [p*AW +: AW]
//   port_write_data_i : per-port write data, port p at [p*DW +: DW]
//   port_read_data_o  : per-port returned read data
//   port_wait_o       : per-port stall (request held until completion)
//   port_err_o        : per-port error for the last completed request
// ============================================================================
module sdram_gated_arb #(
    parameter int NPORTS  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk_ram,
    input  logic                       rst,
    output logic [DW/8-1:0]            ram_wr_o,
    output logic                       ram_rd_o,
    output logic [AW-1:0]              ram_addr_o,
    output logic [DW-1:0]              ram_write_data_o,
    input  logic [DW-1:0]              ram_read_data_i,
    input  logic                       ram_accept_i,
    input  logic                       ram_ack_i,
    input  logic                       ram_error_i,
    input  logic [NPORTS-1:0]          port_ce_i,
    input  logic [NPORTS*(DW/8)-1:0]   port_wr_i,
    input  logic [NPORTS-1:0]          port_rd_i,
    input  logic [NPORTS*AW-1:0]       port_addr_i,
    input  logic [NPORTS*DW-1:0]       port_write_data_i,
    output logic [NPORTS*DW-1:0]       port_read_data_o,
    output logic [NPORTS-1:0]          port_wait_o,
    output logic [NPORTS-1:0]          port_err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_SW  = DW / 8;
    localparam int c_LGW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int c_TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam bit               c_TO_EN    = (TIMEOUT > 0);
    localparam logic [c_TW-1:0]  c_TLIM     = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;
    localparam logic [c_LGW-1:0] c_LAST_RST = c_LGW'(NPORTS - 1);

    // Per-port state
    localparam logic [1:0] c_P_IDLE   = 2'd0;
    localparam logic [1:0] c_P_PEND   = 2'd1;
    localparam logic [1:0] c_P_ACTIVE = 2'd2;

    // RAM-side state
    localparam logic [1:0] c_R_IDLE   = 2'd0;
    localparam logic [1:0] c_R_ISSUE  = 2'd1;
    localparam logic [1:0] c_R_WAIT   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_ram_state_q,  w_ram_state_d;
    logic [c_LGW-1:0]  r_last_grant_q, w_last_grant_d;
    logic [c_TW-1:0]   r_tcnt_q,       w_tcnt_d;

    logic [c_SW-1:0]   r_ram_wr_q,     w_ram_wr_d;
    logic              r_ram_rd_q,     w_ram_rd_d;
    logic [AW-1:0]     r_ram_addr_q,   w_ram_addr_d;
    logic [DW-1:0]     r_ram_wdata_q,  w_ram_wdata_d;

    logic [1:0]        r_pstate_q    [NPORTS];
    logic [1:0]        w_pstate_d    [NPORTS];
    logic [c_SW-1:0]   r_cap_wr_q    [NPORTS];
    logic [c_SW-1:0]   w_cap_wr_d    [NPORTS];
    logic [AW-1:0]     r_cap_addr_q  [NPORTS];
    logic [AW-1:0]     w_cap_addr_d  [NPORTS];
    logic [DW-1:0]     r_cap_wdata_q [NPORTS];
    logic [DW-1:0]     w_cap_wdata_d [NPORTS];
    logic [DW-1:0]     r_prdata_q    [NPORTS];
    logic [DW-1:0]     w_prdata_d    [NPORTS];
    logic [NPORTS-1:0] r_cap_rd_q,     w_cap_rd_d;
    logic [NPORTS-1:0] r_pwait_q,      w_pwait_d;
    logic [NPORTS-1:0] r_perr_q,       w_perr_d;

    // ------------------------------------------------------------------------
    // Unpacked views of the packed client buses
    // ------------------------------------------------------------------------
    logic [c_SW-1:0]   w_in_wr    [NPORTS];
    logic [AW-1:0]     w_in_addr  [NPORTS];
    logic [DW-1:0]     w_in_wdata [NPORTS];
    logic [NPORTS-1:0] w_req;

    generate
        for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
            assign w_in_wr[gp]    = port_wr_i[gp*c_SW +: c_SW];
            assign w_in_addr[gp]  = port_addr_i[gp*AW +: AW];
            assign w_in_wdata[gp] = port_write_data_i[gp*DW +: DW];
            assign w_req[gp]      = port_rd_i[gp] | (|w_in_wr[gp]);
            assign port_read_data_o[gp*DW +: DW] = r_prdata_q[gp];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search: first pending port after the last grant, wrapping.
    // ------------------------------------------------------------------------
    logic             w_any_pend;
    logic [c_LGW-1:0] w_gnt_idx;

    always_comb begin
        int               v_idx;
        logic [c_LGW-1:0] v_cand;
        w_any_pend = 1'b0;
        w_gnt_idx  = r_last_grant_q;
        v_idx      = 0;
        v_cand     = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            v_idx  = (int'(r_last_grant_q) + k) % NPORTS;
            v_cand = c_LGW'(v_idx);
            if (!w_any_pend && (r_pstate_q[v_cand] == c_P_PEND)) begin
                w_any_pend = 1'b1;
                w_gnt_idx  = v_cand;
            end
        end
    end

    // The active port is always the most recent grant, so last_grant doubles
    // as the index of the transaction in flight.
    logic w_act_is_wr;
    logic w_to_hit;

    assign w_act_is_wr = |r_cap_wr_q[r_last_grant_q];
    assign w_to_hit    = c_TO_EN && (r_tcnt_q == c_TLIM);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        logic          v_cpl;
        logic          v_err;
        logic [DW-1:0] v_data;

        v_cpl          = 1'b0;
        v_err          = 1'b0;
        v_data         = '0;
        w_ram_state_d  = r_ram_state_q;
        w_last_grant_d = r_last_grant_q;
        w_tcnt_d       = r_tcnt_q;
        w_ram_wr_d     = r_ram_wr_q;
        w_ram_rd_d     = r_ram_rd_q;
        w_ram_addr_d   = r_ram_addr_q;
        w_ram_wdata_d  = r_ram_wdata_q;
        w_cap_rd_d     = r_cap_rd_q;
        w_pwait_d      = r_pwait_q;
        w_perr_d       = r_perr_q;
        for (int p = 0; p < NPORTS; p++) begin
            w_pstate_d[p]    = r_pstate_q[p];
            w_cap_wr_d[p]    = r_cap_wr_q[p];
            w_cap_addr_d[p]  = r_cap_addr_q[p];
            w_cap_wdata_d[p] = r_cap_wdata_q[p];
            w_prdata_d[p]    = r_prdata_q[p];
        end

        case (r_ram_state_q)
            c_R_IDLE: begin
                // Stray accept/ack here are simply not looked at.
                if (w_any_pend) begin
                    w_ram_state_d         = c_R_ISSUE;
                    w_last_grant_d        = w_gnt_idx;
                    w_tcnt_d              = '0;
                    w_pstate_d[w_gnt_idx] = c_P_ACTIVE;
                    w_ram_wr_d            = r_cap_wr_q[w_gnt_idx];
                    w_ram_rd_d            = r_cap_rd_q[w_gnt_idx];
                    w_ram_addr_d          = r_cap_addr_q[w_gnt_idx];
                    w_ram_wdata_d         = r_cap_wdata_q[w_gnt_idx];
                end
            end

            c_R_ISSUE: begin
                // An ack only counts here when it comes with the accept.
                if (ram_accept_i && ram_ack_i) begin
                    v_cpl  = 1'b1;
                    v_err  = ram_error_i;
                    v_data = w_act_is_wr ? '0 : ram_read_data_i;
                end else if (w_to_hit) begin
                    v_cpl  = 1'b1;
                    v_err  = 1'b1;
                end else begin
                    if (c_TO_EN) begin
                        w_tcnt_d = r_tcnt_q + c_TW'(1);
                    end
                    if (ram_accept_i) begin
                        w_ram_state_d = c_R_WAIT;
                        w_ram_wr_d    = '0;
                        w_ram_rd_d    = 1'b0;
                        w_ram_addr_d  = '0;
                        w_ram_wdata_d = '0;
                    end
                end
            end

            c_R_WAIT: begin
                if (ram_ack_i) begin
                    v_cpl  = 1'b1;
                    v_err  = ram_error_i;
                    v_data = w_act_is_wr ? '0 : ram_read_data_i;
                end else if (w_to_hit) begin
                    v_cpl  = 1'b1;
                    v_err  = 1'b1;
                end else if (c_TO_EN) begin
                    w_tcnt_d = r_tcnt_q + c_TW'(1);
                end
            end

            default: begin
                w_ram_state_d = c_R_IDLE;
            end
        endcase

        if (v_cpl) begin
            w_ram_state_d              = c_R_IDLE;
            w_tcnt_d                   = '0;
            w_ram_wr_d                 = '0;
            w_ram_rd_d                 = 1'b0;
            w_ram_addr_d               = '0;
            w_ram_wdata_d              = '0;
            w_pstate_d[r_last_grant_q] = c_P_IDLE;
            w_pwait_d[r_last_grant_q]  = 1'b0;
            w_perr_d[r_last_grant_q]   = v_err;
            w_prdata_d[r_last_grant_q] = v_data;
        end

        // Capture looks only at the registered port state, so a port that
        // completes on this edge cannot re-capture until the next one, and a
        // capture on another port proceeds independently of the completion.
        for (int p = 0; p < NPORTS; p++) begin
            if ((r_pstate_q[p] == c_P_IDLE) && port_ce_i[p] && w_req[p]) begin
                w_pstate_d[p]    = c_P_PEND;
                w_cap_wr_d[p]    = w_in_wr[p];
                w_cap_rd_d[p]    = port_rd_i[p];
                w_cap_addr_d[p]  = w_in_addr[p];
                w_cap_wdata_d[p] = w_in_wdata[p];
                w_pwait_d[p]     = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            r_ram_state_q  <= c_R_IDLE;
            r_last_grant_q <= c_LAST_RST;
            r_tcnt_q       <= '0;
            r_ram_wr_q     <= '0;
            r_ram_rd_q     <= 1'b0;
            r_ram_addr_q   <= '0;
            r_ram_wdata_q  <= '0;
            r_cap_rd_q     <= '0;
            r_pwait_q      <= '0;
            r_perr_q       <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                r_pstate_q[p]    <= c_P_IDLE;
                r_cap_wr_q[p]    <= '0;
                r_cap_addr_q[p]  <= '0;
                r_cap_wdata_q[p] <= '0;
                r_prdata_q[p]    <= '0;
            end
        end else begin
            r_ram_state_q  <= w_ram_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_tcnt_q       <= w_tcnt_d;
            r_ram_wr_q     <= w_ram_wr_d;
            r_ram_rd_q     <= w_ram_rd_d;
            r_ram_addr_q   <= w_ram_addr_d;
            r_ram_wdata_q  <= w_ram_wdata_d;
            r_cap_rd_q     <= w_cap_rd_d;
            r_pwait_q      <= w_pwait_d;
            r_perr_q       <= w_perr_d;
            for (int p = 0; p < NPORTS; p++) begin
                r_pstate_q[p]    <= w_pstate_d[p];
                r_cap_wr_q[p]    <= w_cap_wr_d[p];
                r_cap_addr_q[p]  <= w_cap_addr_d[p];
                r_cap_wdata_q[p] <= w_cap_wdata_d[p];
                r_prdata_q[p]    <= w_prdata_d[p];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ram_wr_o         = r_ram_wr_q;
    assign ram_rd_o         = r_ram_rd_q;
    assign ram_addr_o       = r_ram_addr_q;
    assign ram_write_data_o = r_ram_wdata_q;
    assign port_wait_o      = r_pwait_q;
    assign port_err_o       = r_perr_q;

endmodule

`default_nettype wire

// File: doc/sdram_gated_arb.md
SDRAM_GATED_ARB -- requirements
Module: sdram_gated_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NPORTS, 2, number of client ports (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8); SW = DW/8 is the byte-strobe width.
- TIMEOUT, 255, maximum cycles from issue to ram_ack_i; 0 disables the timeout.

REQ-002 Ports (name, direction, width, meaning), one per line. Port vectors are packed, with port p at slice [p*W +: W].
- clk_ram, in, 1, single clock for the whole block.
- rst, in, 1, synchronous active-high reset.
- ram_wr_o, out, SW, RAM byte write strobes.
- ram_rd_o, out, 1, RAM read request.
- ram_addr_o, out, AW, RAM address.
- ram_write_data_o, out, DW, RAM write data.
- ram_read_data_i, in, DW, RAM read data, valid with ram_ack_i.
- ram_accept_i, in, 1, RAM has taken the presented request.
- ram_ack_i, in, 1, RAM has completed the request.
- ram_error_i, in, 1, RAM error status, valid with ram_ack_i.
- port_ce_i, in, NPORTS, per-port client-cycle strobe (the gated-clock equivalent).
- port_wr_i, in, NPORTS*SW, client byte write strobes.
- port_rd_i, in, NPORTS, client read request.
- port_addr_i, in, NPORTS*AW, client address.
- port_write_data_i, in, NPORTS*DW, client write data.
- port_read_data_o, out, NPORTS*DW, read data returned to the client.
- port_wait_o, out, NPORTS, client must hold its request and stall.
- port_err_o, out, NPORTS, error for the last completed request.

REQ-003 All logic SHALL be clocked on the rising edge of clk_ram, with the synchronous active-high reset rst.

Function
REQ-004 The port request term SHALL be req[p] = port_rd_i[p] | (port_wr_i[p] != 0).

REQ-005 Per-port state SHALL be IDLE, PEND or ACTIVE.

REQ-006 Request capture:
- Condition: IDLE port, port_ce_i[p]=1 and req[p]=1.
- Action: capture wr/rd/addr/wdata, go to PEND, and set port_wait_o[p]=1 on the next cycle.

REQ-007 A request SHALL be ignored while the port is not IDLE.
- port_ce_i with req=0 SHALL have no effect.

REQ-008 The RAM FSM SHALL have the states IDLE, ISSUE and WAIT_ACK.

REQ-009 Arbitration:
- Applies in RAM IDLE with at least one port in PEND.
- Round-robin grant, searching from last_grant+1 upward with wrap at NPORTS-1.
- The granted port goes to ACTIVE; the FSM goes to ISSUE; ram_* outputs are loaded from the captured request on the same edge.

REQ-010 In ISSUE the ram_* outputs SHALL hold stable.
- ram_accept_i=1 -> WAIT_ACK.
- ram_accept_i=1 together with ram_ack_i=1 -> complete immediately, per REQ-011.

REQ-011 Completion (ram_ack_i=1 in WAIT_ACK, or the same-cycle case in REQ-010):
- Read request: port_read_data_o[p] <= ram_read_data_i.
- Write request: port_read_data_o[p] <= 0.
- port_err_o[p] <= ram_error_i and port_wait_o[p] <= 0.
- Port p returns to IDLE; the FSM returns to IDLE.

REQ-012 The ram_* outputs SHALL be driven to 0 on the cycle after accept.
- The address and data outputs are don't-care outside ISSUE but SHALL be zeroed.

REQ-013 Timeout:
- With TIMEOUT>0, a counter starts at 0 on entry to ISSUE and increments every cycle in ISSUE and WAIT_ACK.
- On count == TIMEOUT-1 without ack: complete with port_err_o[p]=1 and port_read_data_o[p]=0, ram_* outputs zeroed, FSM to IDLE.

REQ-014 ram_ack_i or ram_accept_i arriving while the FSM is IDLE SHALL be discarded with no state change.

REQ-015 A new grant SHALL occur no earlier than the cycle after completion.
- Throughput is at most one RAM transaction per 2 cycles.

REQ-016 port_read_data_o[p] and port_err_o[p] SHALL hold their values until that port's next completion.

REQ-017 Capture and completion on different ports in the same cycle SHALL both take effect.

REQ-018 The counter width SHALL be $clog2(TIMEOUT+1), and last_grant SHALL be $clog2(NPORTS) bits (minimum 1).

Reset
REQ-019 On rst, the following SHALL be cleared on the next edge:
- All ports to IDLE; RAM FSM to IDLE; last_grant to NPORTS-1, so that port 0 wins first.
- Timeout counter to 0.
- ram_wr_o=0, ram_rd_o=0, ram_addr_o=0, ram_write_data_o=0.
- port_read_data_o=0, port_wait_o=0, port_err_o=0.

REQ-020 Reset asserted mid-transaction SHALL abandon that transaction.
- Any ack that arrives afterwards SHALL be discarded per REQ-014.

Verification
REQ-021 Single read:
- Stimulus: port0 ce, rd, addr=0x100; accept after 1 cycle; ack after 3 cycles with data 0xDEADBEEF, error 0.
- Required response: ram_rd_o=1 with ram_addr_o=0x100; port_read_data_o[0]=0xDEADBEEF; port_wait_o[0] falls one cycle after ack; port_err_o[0]=0.

REQ-022 Write strobes:
- Stimulus: port1 ce, wr=4'b0011, wdata=0x12345678.
- Required response: ram_wr_o=4'b0011 and ram_write_data_o=0x12345678 until accept; port_read_data_o[1]=0 after ack.

REQ-023 Round-robin fairness:
- Stimulus: ports 0 and 1 request at the same ce; port 0 re-requests immediately after its completion.
- Required response: grant order 0, 1, 0.

REQ-024 Same-cycle accept and ack:
- Stimulus: ram_accept_i=1 and ram_ack_i=1 in the first ISSUE cycle.
- Required response: completion in that cycle; no WAIT_ACK state entered.

REQ-025 Timeout:
- Stimulus: TIMEOUT=4; request accepted, never acked.
- Required response: port_err_o=1 and data=0 four cycles after grant; a late ack is discarded; the next request proceeds normally.

REQ-026 Reset mid-transaction:
- Stimulus: rst asserted during WAIT_ACK.
- Required response: all outputs 0 on the next cycle; a following ack is ignored.
